// File: rtl/biquad_mac_sequencer.sv
// -----------------------------------------------------------------------------
// biquad_mac_sequencer
//
// Purpose:
//   Drives one shared MAC16 accumulator (Q2.14 x Q2.14 -> Q4.28 accumulate)
//   through a direct-form-I biquad. Each accepted sample x[n] costs five
//   multiply-accumulate taps plus MAC_LAT drain cycles. The result is then
//   rescaled to y[n] in Q2.14. The block owns the filter history
//   (x[n-1], x[n-2], y[n-1], y[n-2]) and every MAC control pin.
//
//   y[n] = b0*x + b1*x1 + b2*x2 + (-a1)*y1 + (-a2)*y2
//
// Optional feature:
//   BIQUAD_SAT_EN  when defined, an out-of-range accumulator (bits [31:29]
//                  not all equal) clamps to 0x7FFF / 0x8000. When undefined,
//                  y_out is the plain two's-complement slice [29:14].
//
// Ports:
//   clk_i          clock, single domain
//   rst_i          synchronous active-high reset
//   in_valid_i     x_in_i and coefficients valid
//   in_ready_o     high only while idle
//   x_in_i         x[n], Q2.14 signed
//   b0_i..b2_i     feed-forward coefficients, Q2.14 signed
//   a1_i, a2_i     feedback coefficients, Q2.14 signed (subtracted)
//   out_valid_o    one-cycle pulse: y_out_o has just been updated
//   y_out_o        y[n], Q2.14 signed, held until the next pulse
//   busy_o         inverse of in_ready_o
//   mac_rst_o      MAC pipeline/accumulator clear
//   mac_ce_o       MAC clock enable
//   mac_a_o        MAC coefficient operand
//   mac_b_o        MAC data operand
//   mac_result_i   MAC accumulator, Q4.28 signed
// -----------------------------------------------------------------------------
module biquad_mac_sequencer #(
  parameter int MAC_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] x_in_i,
  input  logic [15:0] b0_i,
  input  logic [15:0] b1_i,
  input  logic [15:0] b2_i,
  input  logic [15:0] a1_i,
  input  logic [15:0] a2_i,
  output logic        out_valid_o,
  output logic [15:0] y_out_o,
  output logic        busy_o,
  output logic        mac_rst_o,
  output logic        mac_ce_o,
  output logic [15:0] mac_a_o,
  output logic [15:0] mac_b_o,
  input  logic [31:0] mac_result_i
);

  localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_TAP0  = 3'd2,
    ST_TAP1  = 3'd3,
    ST_TAP2  = 3'd4,
    ST_TAP3  = 3'd5,
    ST_TAP4  = 3'd6,
    ST_DRAIN = 3'd7
  } state_e;

  // Saturating negation: -(-2.0) is not representable in Q2.14, so it
  // becomes the largest positive value instead of wrapping back to 0x8000.
  function automatic logic [15:0] neg_sat(input logic [15:0] v);
    if (v == 16'h8000) begin
      return 16'h7FFF;
    end else begin
      return 16'h0000 - v;
    end
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Per-sample operand snapshot, frozen at accept.
  logic [15:0] x_q, x_d;
  logic [15:0] b0_q, b0_d;
  logic [15:0] b1_q, b1_d;
  logic [15:0] b2_q, b2_d;
  logic [15:0] a1_q, a1_d;
  logic [15:0] a2_q, a2_d;

  // Filter history.
  logic [15:0] x1_q, x1_d;
  logic [15:0] x2_q, x2_d;
  logic [15:0] y1_q, y1_d;
  logic [15:0] y2_q, y2_d;

  // Registered outputs.
  logic [15:0] y_q, y_d;
  logic        out_valid_q, out_valid_d;
  logic        mac_ce_q, mac_ce_d;
  logic [15:0] mac_a_q, mac_a_d;
  logic [15:0] mac_b_q, mac_b_d;

  // Result rescaling.
  logic        ovf_s;
  logic [15:0] y_new_s;
  logic        unused_bits_s;

  // Rescale Q4.28 accumulator to Q2.14 (truncate toward -inf), optional clamp.
  always_comb begin
    ovf_s = ~((mac_result_i[31:29] == 3'b000) | (mac_result_i[31:29] == 3'b111));
`ifdef BIQUAD_SAT_EN
    if (ovf_s) begin
      y_new_s = mac_result_i[31] ? 16'h8000 : 16'h7FFF;
    end else begin
      y_new_s = mac_result_i[29:14];
    end
`else
    y_new_s = mac_result_i[29:14];
`endif
    // Fraction bits below the Q2.14 LSB are dropped by design.
    unused_bits_s = ^{mac_result_i[13:0], ovf_s};
  end

  // Next-state, sample capture, history update and next operand selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    mac_ce_d    = 1'b0;
    mac_a_d     = 16'h0000;
    mac_b_d     = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          x_d     = x_in_i;
          b0_d    = b0_i;
          b1_d    = b1_i;
          b2_d    = b2_i;
          a1_d    = a1_i;
          a2_d    = a2_i;
          state_d = ST_CLR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR:  state_d = ST_TAP0;
      ST_TAP0: state_d = ST_TAP1;
      ST_TAP1: state_d = ST_TAP2;
      ST_TAP2: state_d = ST_TAP3;
      ST_TAP3: state_d = ST_TAP4;
      ST_TAP4: begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          // The last product has landed in the accumulator: take the result.
          state_d     = ST_IDLE;
          cnt_d       = '0;
          y_d         = y_new_s;
          out_valid_d = 1'b1;
          x2_d        = x1_q;
          x1_d        = x_q;
          y2_d        = y1_q;
          y1_d        = y_new_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Operands are registered, so they are chosen for the state being entered.
    case (state_d)
      ST_TAP0: begin
        mac_ce_d = 1'b1;
        mac_a_d  = b0_q;
        mac_b_d  = x_q;
      end
      ST_TAP1: begin
        mac_ce_d = 1'b1;
        mac_a_d  = b1_q;
        mac_b_d  = x1_q;
      end
      ST_TAP2: begin
        mac_ce_d = 1'b1;
        mac_a_d  = b2_q;
        mac_b_d  = x2_q;
      end
      ST_TAP3: begin
        mac_ce_d = 1'b1;
        mac_a_d  = neg_sat(a1_q);
        mac_b_d  = y1_q;
      end
      ST_TAP4: begin
        mac_ce_d = 1'b1;
        mac_a_d  = neg_sat(a2_q);
        mac_b_d  = y2_q;
      end
      ST_DRAIN: begin
        mac_ce_d = 1'b1;
      end
      default: begin
        mac_ce_d = 1'b0;
      end
    endcase
  end

  // State, snapshot, history and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= 16'h0000;
      b0_q        <= 16'h0000;
      b1_q        <= 16'h0000;
      b2_q        <= 16'h0000;
      a1_q        <= 16'h0000;
      a2_q        <= 16'h0000;
      x1_q        <= 16'h0000;
      x2_q        <= 16'h0000;
      y1_q        <= 16'h0000;
      y2_q        <= 16'h0000;
      y_q         <= 16'h0000;
      out_valid_q <= 1'b0;
      mac_ce_q    <= 1'b0;
      mac_a_q     <= 16'h0000;
      mac_b_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      mac_ce_q    <= mac_ce_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign busy_o      = ~in_ready_o;
  // The MAC clear follows the reset pin directly so the MAC is cleared
  // in the same cycles as this block.
  assign mac_rst_o   = rst_i | (state_q == ST_CLR);
  assign mac_ce_o    = mac_ce_q;
  assign mac_a_o     = mac_a_q;
  assign mac_b_o     = mac_b_q;
  assign out_valid_o = out_valid_q;
  assign y_out_o     = y_q;

endmodule

// File: tb/tb_biquad_mac_sequencer.sv
module tb_biquad_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in, b0, b1, b2, a1, a2;
  logic        out_valid;
  logic [15:0] y_out;
  logic        busy;
  logic        mac_rst;
  logic        mac_ce;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_result;

  int ntests = 0;
  int nfail  = 0;

  biquad_mac_sequencer #(.MAC_LAT(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .x_in_i       (x_in),
    .b0_i         (b0),
    .b1_i         (b1),
    .b2_i         (b2),
    .a1_i         (a1),
    .a2_i         (a2),
    .out_valid_o  (out_valid),
    .y_out_o      (y_out),
    .busy_o       (busy),
    .mac_rst_o    (mac_rst),
    .mac_ce_o     (mac_ce),
    .mac_a_o      (mac_a),
    .mac_b_o      (mac_b),
    .mac_result_i (mac_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC16 wrapper model: operand-to-result latency of 2 cycles.
  logic signed [31:0] p_q;
  logic signed [31:0] acc_q;
  always @(posedge clk) begin
    if (mac_rst) begin
      p_q   <= 32'sd0;
      acc_q <= 32'sd0;
    end else if (mac_ce) begin
      p_q   <= $signed(mac_a) * $signed(mac_b);
      acc_q <= acc_q + p_q;
    end
  end
  assign mac_result = acc_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One sample: accept, follow it through, check operands, result and latency.
  task automatic run_sample(input logic [15:0] xv, input logic [15:0] c_b0,
                            input logic [15:0] c_b1, input logic [15:0] c_b2,
                            input logic [15:0] c_a1, input logic [15:0] c_a2,
                            input logic [15:0] exp_y, input string tag);
    int w;
    int lat;
    @(negedge clk);
    x_in = xv; b0 = c_b0; b1 = c_b1; b2 = c_b2; a1 = c_a1; a2 = c_a2;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        // Scramble inputs: the frozen snapshot must be used.
        in_valid = 1'b0;
        x_in = 16'hDEAD; b0 = 16'hBEEF; b1 = 16'h1234;
        b2 = 16'h5678; a1 = 16'h9ABC; a2 = 16'hCDEF;
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
      end
      if (n == 2) begin
        check({tag, "_tap0_a"}, {16'd0, mac_a}, {16'd0, c_b0});
        check({tag, "_tap0_b"}, {16'd0, mac_b}, {16'd0, xv});
      end
      if (out_valid) begin
        lat = n;
        check({tag, "_y"}, {16'd0, y_out}, {16'd0, exp_y});
        check({tag, "_ready_at_out"}, {31'd0, in_ready}, 32'd1);
      end
    end
    check({tag, "_latency"}, lat, 32'd9);
  endtask

  initial begin
    int acc_cyc [4];
    int nacc, ce_cnt, rst_cnt, ov_cnt, c;

    rst = 1'b1; in_valid = 1'b0;
    x_in = 16'h0000; b0 = 16'h0000; b1 = 16'h0000;
    b2 = 16'h0000; a1 = 16'h0000; a2 = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y_out",     {16'd0, y_out},     32'd0);
    check("rst_mac_ce",    {31'd0, mac_ce},    32'd0);
    check("rst_mac_a",     {16'd0, mac_a},     32'd0);
    check("rst_mac_b",     {16'd0, mac_b},     32'd0);
    check("rst_mac_rst",   {31'd0, mac_rst},   32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_mac_rst",  {31'd0, mac_rst},   32'd0);

    // Impulse
    run_sample(16'h4000, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2000, "imp0");
    run_sample(16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "imp1");

    // Feedback through y1
    reset_dut();
    run_sample(16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h4000, "fb0");
    run_sample(16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'hE000, "fb1");
    run_sample(16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h1000, "fb2");

    // Overflow
    reset_dut();
`ifdef BIQUAD_SAT_EN
    run_sample(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, "ovf0");
    run_sample(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, "ovf1");
`else
    run_sample(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFC, "ovf0");
    run_sample(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFF8, "ovf1");
`endif

    // Saturating negation of a1 = -2.0
    reset_dut();
    run_sample(16'h4000, 16'h1000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h1000, "neg0");
    run_sample(16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h1FFF, "neg1");

    // Back-to-back handshake with in_valid held high
    reset_dut();
    @(negedge clk);
    x_in = 16'h4000; b0 = 16'h2000; b1 = 16'h0000;
    b2 = 16'h0000; a1 = 16'h0000; a2 = 16'h0000;
    in_valid = 1'b1;
    nacc = 0; ce_cnt = 0; rst_cnt = 0; ov_cnt = 0;
    for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
    for (c = 0; c < 50; c++) begin
      if (mac_ce) ce_cnt++;
      if (mac_rst) rst_cnt++;
      if (out_valid) begin
        ov_cnt++;
        check("b2b_y", {16'd0, y_out}, 32'h2000);
      end
      if (in_ready) begin
        if (nacc < 4) begin
          acc_cyc[nacc] = c;
          nacc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_accepts", nacc, 32'd4);
    check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 32'd9);
    check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 32'd9);
    check("b2b_gap3", acc_cyc[3] - acc_cyc[2], 32'd9);
    check("b2b_mac_ce_cycles", ce_cnt, 32'd28);
    check("b2b_mac_rst_cycles", rst_cnt, 32'd4);
    check("b2b_out_valid_count", ov_cnt, 32'd4);

    // Reset during TAP2 with non-zero history
    reset_dut();
    run_sample(16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h4000, "pre");
    @(negedge clk);
    x_in = 16'h4000; in_valid = 1'b1;
    @(posedge clk);
    ov_cnt = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) in_valid = 1'b0;
      if (out_valid) ov_cnt++;
    end
    check("mid_tap2_ce", {31'd0, mac_ce}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_y_out", {16'd0, y_out}, 32'd0);
    check("mid_mac_ce", {31'd0, mac_ce}, 32'd0);
    for (int n = 0; n < 12; n++) begin
      if (out_valid) ov_cnt++;
      @(negedge clk);
    end
    check("mid_no_out_valid", ov_cnt, 32'd0);
    // With x1 and y1 cleared this tap set yields zero.
    run_sample(16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, "hist_clr");
    run_sample(16'h4000, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2000, "rerun0");
    run_sample(16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "rerun1");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
